// File: rtl/seg_frame_sched_if.sv
// Segmented beat bus between the upstream framer and the frame scheduler.
// The raw per-segment markers go in and the validated LUT-pipe bundle comes out.
interface seg_frame_sched_if #(
  parameter int SEG_NUM   = 64,
  parameter int BUS_WIDTH = 64,
  parameter int EMPTY_W   = 3
);
  logic                           in_valid;
  logic [SEG_NUM-1:0]             in_seg_sop;
  logic [SEG_NUM-1:0]             in_seg_eop;
  logic [SEG_NUM*EMPTY_W-1:0]     in_seg_empty;
  logic [SEG_NUM*BUS_WIDTH-1:0]   in_data;

  logic [SEG_NUM-1:0]             seg_sop;
  logic [SEG_NUM-1:0]             seg_eop;
  logic [SEG_NUM-1:0]             seg_dval;
  logic [SEG_NUM*4-1:0]           seg_packet_num;
  logic [SEG_NUM*12-1:0]          seg_zero_num;
  logic [SEG_NUM*BUS_WIDTH-1:0]   seg_dout;

  modport master (
    output in_valid, in_seg_sop, in_seg_eop, in_seg_empty, in_data,
    input  seg_sop, seg_eop, seg_dval, seg_packet_num, seg_zero_num, seg_dout
  );

  modport slave (
    input  in_valid, in_seg_sop, in_seg_eop, in_seg_empty, in_data,
    output seg_sop, seg_eop, seg_dval, seg_packet_num, seg_zero_num, seg_dout
  );
endinterface

// File: rtl/seg_frame_sched.sv
// Front-end sequencer for the segmented CRC LUT pipe: validates per-segment
// framing, numbers packets mod 16 and registers the per-segment bundle.
module seg_frame_sched #(
  parameter int SEG_NUM   = 64,
  parameter int BUS_WIDTH = 64,
  parameter int EMPTY_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  seg_frame_sched_if.slave    bus,
  output logic                err_pulse,
  output logic [15:0]         err_cnt
);

  localparam int SEG_BYTES = BUS_WIDTH / 8;

  logic                         in_pkt_q;
  logic [3:0]                   pkt_cnt_q;
  logic [3:0]                   cur_id_q;
  logic [15:0]                  err_cnt_q, err_cnt_d;
  logic                         err_pulse_q;

  logic [SEG_NUM-1:0]           sop_q, sop_d;
  logic [SEG_NUM-1:0]           eop_q, eop_d;
  logic [SEG_NUM-1:0]           dval_q, dval_d;
  logic [SEG_NUM*4-1:0]         pnum_q, pnum_d;
  logic [SEG_NUM*12-1:0]        zn_q, zn_d;
  logic [SEG_NUM*BUS_WIDTH-1:0] dout_q;

  logic                         scan_open;
  logic [3:0]                   scan_id;
  logic [3:0]                   scan_nsop;
  logic                         scan_err;

  // Walk segments in time order; the open/id state ripples segment to segment.
  always_comb begin
    sop_d     = '0;
    eop_d     = '0;
    dval_d    = '0;
    pnum_d    = '0;
    zn_d      = '0;
    scan_open = in_pkt_q;
    scan_id   = cur_id_q;
    scan_nsop = '0;
    scan_err  = 1'b0;
    for (int unsigned k = 0; k < SEG_NUM; k++) begin
      if (bus.in_seg_sop[k]) begin
        // An sop inside an open packet abandons it and starts a fresh one.
        if (scan_open) scan_err = 1'b1;
        scan_id   = pkt_cnt_q + scan_nsop;
        scan_nsop = scan_nsop + 4'd1;
        scan_open = 1'b1;
        sop_d[k]  = 1'b1;
      end
      if (scan_open) begin
        dval_d[k]         = 1'b1;
        pnum_d[k*4 +: 4]  = scan_id;
      end
      if (bus.in_seg_eop[k]) begin
        if (scan_open) begin
          eop_d[k]          = 1'b1;
          zn_d[k*12 +: 12]  = 12'(int'(bus.in_seg_empty[k*EMPTY_W +: EMPTY_W])
                                  + int'(SEG_NUM - 1 - k) * SEG_BYTES);
          scan_open         = 1'b0;
        end else begin
          scan_err = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.in_valid && scan_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_pkt_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      cur_id_q    <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      sop_q       <= '0;
      eop_q       <= '0;
      dval_q      <= '0;
      pnum_q      <= '0;
      zn_q        <= '0;
      dout_q      <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (bus.in_valid) begin
        in_pkt_q    <= scan_open;
        pkt_cnt_q   <= pkt_cnt_q + scan_nsop;
        cur_id_q    <= scan_id;
        err_pulse_q <= scan_err;
        sop_q       <= sop_d;
        eop_q       <= eop_d;
        dval_q      <= dval_d;
        pnum_q      <= pnum_d;
        zn_q        <= zn_d;
        dout_q      <= bus.in_data;
      end else begin
        err_pulse_q <= 1'b0;
        sop_q       <= '0;
        eop_q       <= '0;
        dval_q      <= '0;
        pnum_q      <= '0;
        zn_q        <= '0;
      end
    end
  end

  assign bus.seg_sop        = sop_q;
  assign bus.seg_eop        = eop_q;
  assign bus.seg_dval       = dval_q;
  assign bus.seg_packet_num = pnum_q;
  assign bus.seg_zero_num   = zn_q;
  assign bus.seg_dout       = dout_q;
  assign err_pulse          = err_pulse_q;
  assign err_cnt            = err_cnt_q;

endmodule

// File: tb/tb_seg_frame_sched.sv
// Directed bench for seg_frame_sched (4 segments x 64 bits): a packet-level
// model predicts every output cycle, plus literal expectations on key beats.
module tb_seg_frame_sched;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic err_pulse;
  logic [15:0] err_cnt;

  seg_frame_sched_if #(.SEG_NUM(N), .BUS_WIDTH(64), .EMPTY_W(3)) bus_if ();

  seg_frame_sched #(.SEG_NUM(N), .BUS_WIDTH(64), .EMPTY_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  int m_open, m_id, m_cnt, m_errcnt;

  logic [3:0]   exp_dval, exp_sop, exp_eop;
  logic [15:0]  exp_pnum;
  logic [47:0]  exp_zn;
  logic [255:0] exp_dout;
  logic         exp_errp;
  logic [15:0]  exp_errcnt;

  logic         chk_en = 1'b0;
  logic         lit_en = 1'b0;
  logic [3:0]   lit_dval, lit_sop, lit_eop;
  logic [15:0]  lit_pnum;
  logic [47:0]  lit_zn;
  logic         lit_errp;
  logic [15:0]  lit_errcnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_id = 0; m_cnt = 0; m_errcnt = 0;
    exp_dval = '0; exp_sop = '0; exp_eop = '0; exp_pnum = '0; exp_zn = '0;
    exp_dout = '0; exp_errp = 1'b0; exp_errcnt = '0;
  endtask

  // Packets are numbered in order of accepted sop; an eop closes the open packet.
  task automatic model_beat(input logic v, input logic [3:0] s, input logic [3:0] e,
                            input logic [11:0] emp, input logic [255:0] d);
    bit err;
    int n;
    exp_dval = '0; exp_sop = '0; exp_eop = '0; exp_pnum = '0; exp_zn = '0;
    exp_errp = 1'b0;
    if (!v) return;
    err = 0;
    n = 0;
    for (int k = 0; k < N; k++) begin
      if (s[k]) begin
        if (m_open != 0) err = 1;
        m_id = (m_cnt + n) % 16;
        n++;
        m_open = 1;
        exp_sop[k] = 1'b1;
      end
      if (m_open != 0) begin
        exp_dval[k] = 1'b1;
        exp_pnum[k*4 +: 4] = 4'(m_id);
      end
      if (e[k]) begin
        if (m_open != 0) begin
          exp_eop[k] = 1'b1;
          exp_zn[k*12 +: 12] = 12'((int'(emp[k*3 +: 3]) + (N - 1 - k) * 8) % 4096);
          m_open = 0;
        end else begin
          err = 1;
        end
      end
    end
    m_cnt = (m_cnt + n) % 16;
    if (err && m_errcnt < 65535) m_errcnt++;
    exp_errp = err;
    exp_errcnt = 16'(m_errcnt);
    exp_dout = d;
  endtask

  task automatic beat(input logic v, input logic [3:0] s, input logic [3:0] e,
                      input logic [11:0] emp);
    logic [255:0] d;
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus_if.in_valid     = v;
    bus_if.in_seg_sop   = s;
    bus_if.in_seg_eop   = e;
    bus_if.in_seg_empty = emp;
    bus_if.in_data      = d;
    lit_en = 1'b0;
    model_beat(v, s, e, emp, d);
  endtask

  task automatic lit(input logic [3:0] dv, input logic [3:0] sp, input logic [3:0] ep,
                     input logic [15:0] pn, input logic [47:0] zn,
                     input logic errp, input logic [15:0] ec);
    lit_en = 1'b1;
    lit_dval = dv; lit_sop = sp; lit_eop = ep; lit_pnum = pn; lit_zn = zn;
    lit_errp = errp; lit_errcnt = ec;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    lit_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Compare process: outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("dval",    256'(bus_if.seg_dval),       256'(exp_dval));
        chk("sop",     256'(bus_if.seg_sop),        256'(exp_sop));
        chk("eop",     256'(bus_if.seg_eop),        256'(exp_eop));
        chk("pnum",    256'(bus_if.seg_packet_num), 256'(exp_pnum));
        chk("zero",    256'(bus_if.seg_zero_num),   256'(exp_zn));
        chk("dout",    bus_if.seg_dout,             exp_dout);
        chk("errp",    256'(err_pulse),             256'(exp_errp));
        chk("errcnt",  256'(err_cnt),               256'(exp_errcnt));
        if (lit_en) begin
          chk("lit_dval",   256'(bus_if.seg_dval),       256'(lit_dval));
          chk("lit_sop",    256'(bus_if.seg_sop),        256'(lit_sop));
          chk("lit_eop",    256'(bus_if.seg_eop),        256'(lit_eop));
          chk("lit_pnum",   256'(bus_if.seg_packet_num), 256'(lit_pnum));
          chk("lit_zero",   256'(bus_if.seg_zero_num),   256'(lit_zn));
          chk("lit_errp",   256'(err_pulse),             256'(lit_errp));
          chk("lit_errcnt", 256'(err_cnt),               256'(lit_errcnt));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus_if.in_valid     = 1'b0;
    bus_if.in_seg_sop   = '0;
    bus_if.in_seg_eop   = '0;
    bus_if.in_seg_empty = '0;
    bus_if.in_data      = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single beat packet, empty[3]=2
    beat(1'b1, 4'b0001, 4'b1000, 12'o2000);
    lit(4'b1111, 4'b0001, 4'b1000, 16'h0000, 48'h002000000000, 1'b0, 16'd0);

    // Packet spanning two beats, then a one-segment packet to expose pkt_cnt=1
    do_reset();
    beat(1'b1, 4'b0100, 4'b0000, 12'o0000);
    lit(4'b1100, 4'b0100, 4'b0000, 16'h0000, 48'h0, 1'b0, 16'd0);
    beat(1'b1, 4'b0000, 4'b0010, 12'o0050);
    lit(4'b0011, 4'b0000, 4'b0010, 16'h0000, 48'h000000015000, 1'b0, 16'd0);
    beat(1'b1, 4'b0001, 4'b0001, 12'o0000);
    lit(4'b0001, 4'b0001, 4'b0001, 16'h0001, 48'h000000000018, 1'b0, 16'd0);

    // Two packets in one beat
    do_reset();
    beat(1'b1, 4'b0011, 4'b1001, 12'o0000);
    lit(4'b1111, 4'b0011, 4'b1001, 16'h1110, 48'h000000000018, 1'b0, 16'd0);
    beat(1'b1, 4'b0001, 4'b0001, 12'o0000);
    lit(4'b0001, 4'b0001, 4'b0001, 16'h0002, 48'h000000000018, 1'b0, 16'd0);

    // Orphan eop, then sop inside an open packet
    do_reset();
    beat(1'b1, 4'b0110, 4'b0101, 12'o0000);
    lit(4'b0110, 4'b0110, 4'b0100, 16'h0100, 48'h000008000000, 1'b1, 16'd1);
    beat(1'b1, 4'b0000, 4'b0000, 12'o0000);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b0, 16'd1);

    // Saturation of the error counter
    beat(1'b0, 4'b0000, 4'b0000, 12'o0000);
    force dut.err_cnt_q = 16'hFFFF;
    m_errcnt = 65535;
    exp_errcnt = 16'hFFFF;
    beat(1'b0, 4'b0000, 4'b0000, 12'o0000);
    release dut.err_cnt_q;
    beat(1'b1, 4'b0000, 4'b0001, 12'o0000);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b1, 16'hFFFF);
    beat(1'b1, 4'b0000, 4'b0001, 12'o0000);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b1, 16'hFFFF);

    // Packet number wrap over 17 single-segment packets
    do_reset();
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, 4'b0001, 4'b0001, 12'o0000);
      if (i == 15) lit(4'b0001, 4'b0001, 4'b0001, 16'h000F, 48'h000000000018, 1'b0, 16'd0);
      if (i == 16) lit(4'b0001, 4'b0001, 4'b0001, 16'h0000, 48'h000000000018, 1'b0, 16'd0);
    end

    // Reset in the middle of an open packet
    do_reset();
    beat(1'b1, 4'b0001, 4'b0000, 12'o0000);
    lit(4'b1111, 4'b0001, 4'b0000, 16'h0000, 48'h0, 1'b0, 16'd0);
    do_reset();
    beat(1'b1, 4'b0000, 4'b0000, 12'o0000);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b0, 16'd0);
    beat(1'b1, 4'b0000, 4'b0001, 12'o0000);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b1, 16'd1);
    beat(1'b0, 4'b1111, 4'b1111, 12'o7777);
    lit(4'b0000, 4'b0000, 4'b0000, 16'h0000, 48'h0, 1'b0, 16'd1);

    // Mixed traffic with gaps; the model alone predicts these
    beat(1'b1, 4'b1010, 4'b0100, 12'o0700);
    beat(1'b0, 4'b0000, 4'b0000, 12'o0000);
    beat(1'b1, 4'b0000, 4'b0010, 12'o0030);
    beat(1'b1, 4'b1001, 4'b1001, 12'o1004);

    @(negedge clk);
    lit_en = 1'b0;
    bus_if.in_valid = 1'b0;
    model_beat(1'b0, 4'b0000, 4'b0000, 12'o0000, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_frame_sched.md
Name: seg_frame_sched

Overview:
- Front-end sequencer for the segmented CRC LUT pipeline.
- Accepts a wide beat split into SEG_NUM segments, each with raw per-segment sop/eop/empty markers.
- Tracks packet framing across segments and beats, and assigns a rolling 4-bit packet number to each packet.
- Produces the per-segment seg_sop/seg_eop/seg_dval/seg_packet_num/seg_zero_num/seg_dout bundle that drives the multi-segment LUT pipe, registered once; malformed framing is dropped and counted.

Parameters:
- SEG_NUM, 64, number of segments per beat; segment 0 is earliest in time and occupies the lowest bits.
- BUS_WIDTH, 64, bits per segment; SEG_BYTES = BUS_WIDTH/8.
- EMPTY_W, 3, width of the per-segment empty-byte field; equals log2(SEG_BYTES).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid; no ready, upstream never stalled.
- in_seg_sop  in  SEG_NUM  per-segment start-of-packet.
- in_seg_eop  in  SEG_NUM  per-segment end-of-packet.
- in_seg_empty  in  SEG_NUM*EMPTY_W  unused trailing bytes in an eop segment; field k at [k*EMPTY_W +: EMPTY_W].
- in_data  in  SEG_NUM*BUS_WIDTH  beat data.
- seg_sop  out  SEG_NUM  validated sop.
- seg_eop  out  SEG_NUM  validated eop.
- seg_dval  out  SEG_NUM  segment belongs to an accepted packet.
- seg_packet_num  out  SEG_NUM*4  packet number of segment k at [4k +: 4].
- seg_zero_num  out  SEG_NUM*12  bytes from eop to end of beat at [12k +: 12].
- seg_dout  out  SEG_NUM*BUS_WIDTH  registered in_data.
- err_pulse  out  1  one-cycle pulse when a framing error is found in the beat.
- err_cnt  out  16  saturating framing-error count.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, in_pkt=0, pkt_cnt=0, cur_id=0, err_cnt=0.
- Latency: exactly 1 clk, input beat to output registers. There is no backpressure.
- in_valid=0: next cycle seg_sop/seg_eop/seg_dval all 0; seg_dout holds its last value; in_pkt, pkt_cnt and cur_id unchanged.
- Per-beat scan, segment 0 to SEG_NUM-1. State starts at the registered in_pkt/cur_id and is updated segment by segment.
- Case 1: sop=1 and in_pkt=0 → accept. id=pkt_cnt+(sops accepted earlier in this beat), mod 16; seg_sop=1, dval=1.
- Case 2: sop=1 and in_pkt=1 → error. The previous packet is abandoned with no eop emitted; the segment is accepted as a new packet as in case 1.
- Case 3: sop=0, eop=0, in_pkt=1 → dval=1, packet number = current id.
- Case 4: eop=1 with in_pkt=1 after the sop step (covers sop&eop in the same segment) → seg_eop=1, dval=1, in_pkt←0.
  - seg_zero_num = empty + (SEG_NUM-1-k)*SEG_BYTES, truncated to 12 bits.
- Case 5: eop=1, sop=0, in_pkt=0 → error; dval=0, eop dropped.
- Case 6: sop=0, eop=0, in_pkt=0 → idle gap; dval=0.
- Non-dval segments and non-eop segments output packet_num=0 and zero_num=0.
- End of beat:
  - in_pkt register ← final scan state.
  - pkt_cnt ← pkt_cnt + (accepted sops) mod 16.
  - cur_id ← id of the open packet, if any.
- err_pulse=1 in the output cycle if the beat had ≥1 error.
- err_cnt increments by 1 per errored beat, not per error, and saturates at 0xFFFF.
- Packet number wraps 15 → 0 with no special handling.
- The ≥16-packets-in-one-beat case is not supported; ids alias mod 16.
- Reset mid-packet: in_pkt cleared. Continuation segments after reset release are gaps (case 6); a trailing eop is an error (case 5).

Test Plan (SEG_NUM=4, BUS_WIDTH=64):
- Single beat: sop[0], eop[3], empty[3]=2 → next cycle dval=4'b1111, seg_sop=4'b0001, seg_eop=4'b1000, packet_num all 0, zero_num[3]=2, err_pulse=0.
- Spanning two beats: beat A sop[2] (dval=1100, pkt 0); beat B eop[1], empty=5 → beat B out dval=0011, zero_num[1]=5+2*8=21, pkt_cnt=1.
- Two packets in one beat: sop[0]&eop[0], sop[1], eop[3] → packet_num[0]=0, packet_num[1..3]=1, pkt_cnt ends at 2.
- Errors in one beat: eop[0] with no open packet, then sop[1], sop[2] → dval=0110, pkt ids 0 then 1, err_pulse=1 for one cycle, err_cnt=1.
  - Force err_cnt=0xFFFF and repeat → err_cnt stays 0xFFFF.
- Wrap: 17 single-segment packets → the 17th carries packet_num 0.
- Reset: rst low mid-packet, then a beat with eop[0] → dval=0, err_cnt=1. A gap beat with in_valid=0 → all flags 0.
